// File: rtl/ibex_prefetch_checker_pkg.sv
// rtl/ibex_prefetch_checker_pkg.sv - shared error indices, codes and helpers for the prefetch checker
package ibex_prefetch_checker_pkg;

  // Bit positions inside err_flags_o
  localparam int unsigned ERR_SPURIOUS     = 0;
  localparam int unsigned ERR_OVERFLOW     = 1;
  localparam int unsigned ERR_REQ_UNSTABLE = 2;
  localparam int unsigned ERR_ADDR_SEQ     = 3;
  localparam int unsigned ERR_BUSY         = 4;
  localparam int unsigned NumErr           = 5;

  // Code reported on first_err_o; always flag index + 1
  typedef enum logic [2:0] {
    ERR_NONE           = 3'd0,
    ECODE_SPURIOUS     = 3'd1,
    ECODE_OVERFLOW     = 3'd2,
    ECODE_REQ_UNSTABLE = 3'd3,
    ECODE_ADDR_SEQ     = 3'd4,
    ECODE_BUSY         = 3'd5
  } err_code_e;

  // Instruction length in bytes from the low opcode bits: 11 is a full 32-bit
  // instruction, anything else is compressed
  function automatic logic [2:0] inc_len(input logic [1:0] rdata);
    return (rdata == 2'b11) ? 3'd4 : 3'd2;
  endfunction

endpackage

// File: rtl/ibex_prefetch_checker_sat_cnt.sv
// rtl/ibex_prefetch_checker_sat_cnt.sv - saturating event counter with synchronous clear
module ibex_prefetch_checker_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  // Count qualifying cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != {Width{1'b1}})) begin
      cnt_o <= cnt_o + Width'(1);
    end
  end

endmodule

// File: rtl/ibex_prefetch_checker.sv
// rtl/ibex_prefetch_checker.sv - passive protocol checker and statistics for the ibex prefetch buffer
module ibex_prefetch_checker
  import ibex_prefetch_checker_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CntWidth       = 16,
  parameter bit          CheckAddrSeq   = 1'b1,
  localparam int unsigned OutWidth      = $clog2(MaxOutstanding + 2)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 branch_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 valid_o,
  input  logic                 ready_i,
  input  logic [AddrWidth-1:0] addr_o,
  input  logic [31:0]          rdata_o,
  input  logic                 busy_o,
  input  logic                 instr_req_o,
  input  logic                 instr_gnt_i,
  input  logic [AddrWidth-1:0] instr_addr_o,
  input  logic                 instr_rvalid_i,
  output logic [NumErr-1:0]    err_flags_o,
  output logic [2:0]           first_err_o,
  output logic [OutWidth-1:0]  outstanding_o,
  output logic [CntWidth-1:0]  fetch_cnt_o,
  output logic [CntWidth-1:0]  branch_cnt_o,
  output logic [CntWidth-1:0]  stall_cnt_o
);

  localparam logic [OutWidth-1:0] OutMax = OutWidth'(MaxOutstanding);
  localparam logic [OutWidth-1:0] OutSat = OutWidth'(MaxOutstanding + 1);

  logic [OutWidth-1:0]  out_q, out_d;
  logic                 pend_q;
  logic [AddrWidth-1:0] pend_addr_q;
  logic [AddrWidth-1:0] exp_q;
  logic                 exp_known_q;
  logic [NumErr-1:0]    flags_q, new_err;
  err_code_e            first_q, new_code;
  logic                 grant, resp, fetch;

  // Only the length bits of the instruction matter to the checker
  logic unused_rdata;
  assign unused_rdata = ^rdata_o[31:2];

  assign grant = instr_req_o & instr_gnt_i;
  assign resp  = instr_rvalid_i;
  assign fetch = valid_o & ready_i;

  // Evaluate every rule against the current cycle and compute the next outstanding count
  always_comb begin
    out_d   = out_q;
    new_err = '0;
    if (grant && !resp) begin
      if (out_q >= OutMax) begin
        new_err[ERR_OVERFLOW] = 1'b1;
        out_d                 = OutSat;
      end else begin
        out_d = out_q + OutWidth'(1);
      end
    end else if (resp && !grant) begin
      if (out_q == '0) begin
        new_err[ERR_SPURIOUS] = 1'b1;
      end else begin
        out_d = out_q - OutWidth'(1);
      end
    end
    // A stalled request must be held with the same address unless the core redirects
    if (pend_q && !branch_i && (!instr_req_o || (instr_addr_o != pend_addr_q))) begin
      new_err[ERR_REQ_UNSTABLE] = 1'b1;
    end
    if (CheckAddrSeq && valid_o && exp_known_q && (addr_o != exp_q) && !branch_i) begin
      new_err[ERR_ADDR_SEQ] = 1'b1;
    end
    if ((out_q != '0) && !busy_o) begin
      new_err[ERR_BUSY] = 1'b1;
    end
  end

  // Lowest-numbered rule wins when several fire together
  always_comb begin
    new_code = ERR_NONE;
    for (int i = NumErr - 1; i >= 0; i--) begin
      if (new_err[i]) begin
        new_code = err_code_e'(3'(i + 1));
      end
    end
  end

  // Bus and fetch-sequence tracking; survives clear_i, only reset discards it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      exp_q       <= '0;
      exp_known_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      pend_q      <= instr_req_o & ~instr_gnt_i;
      pend_addr_q <= instr_addr_o;
      if (branch_i) begin
        exp_q       <= addr_i;
        exp_known_q <= 1'b1;
      end else if (fetch) begin
        exp_q <= exp_q + AddrWidth'(inc_len(rdata_o[1:0]));
      end
    end
  end

  // Sticky flags and first-error capture; a new error still lands during clear_i
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flags_q <= '0;
      first_q <= ERR_NONE;
    end else if (clear_i) begin
      flags_q <= new_err;
      first_q <= new_code;
    end else begin
      flags_q <= flags_q | new_err;
      if (first_q == ERR_NONE) begin
        first_q <= new_code;
      end
    end
  end

  assign err_flags_o   = flags_q;
  assign first_err_o   = first_q;
  assign outstanding_o = out_q;

  ibex_prefetch_checker_sat_cnt #(.Width(CntWidth)) u_fetch_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (fetch),
    .clr_i (clear_i),
    .cnt_o (fetch_cnt_o)
  );

  ibex_prefetch_checker_sat_cnt #(.Width(CntWidth)) u_branch_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (branch_i),
    .clr_i (clear_i),
    .cnt_o (branch_cnt_o)
  );

  ibex_prefetch_checker_sat_cnt #(.Width(CntWidth)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (valid_o & ~ready_i),
    .clr_i (clear_i),
    .cnt_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_ibex_prefetch_checker.sv
// tb/tb_ibex_prefetch_checker.sv - directed self-checking bench for ibex_prefetch_checker
module tb_ibex_prefetch_checker;

  localparam int MAXO   = 2;
  localparam int CW     = 16;
  localparam int CNTMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst, clear, branch, valid, ready, busy, req, gnt, rvalid;
  logic [31:0] addr_i, addr_o, rdata, iaddr;
  logic [4:0]  flags;
  logic [2:0]  first;
  logic [1:0]  outst;
  logic [15:0] fcnt, bcnt, scnt;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  ibex_prefetch_checker #(
    .AddrWidth(32), .MaxOutstanding(MAXO), .CntWidth(CW), .CheckAddrSeq(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .branch_i(branch), .addr_i(addr_i),
    .valid_o(valid), .ready_i(ready), .addr_o(addr_o), .rdata_o(rdata), .busy_o(busy),
    .instr_req_o(req), .instr_gnt_i(gnt), .instr_addr_o(iaddr), .instr_rvalid_i(rvalid),
    .err_flags_o(flags), .first_err_o(first), .outstanding_o(outst),
    .fetch_cnt_o(fcnt), .branch_cnt_o(bcnt), .stall_cnt_o(scnt)
  );

  // Reference model: counts as plain integers, rules evaluated directly from the input story
  int          m_out, m_first, m_fetch, m_branch, m_stall;
  logic [4:0]  m_flags;
  logic [31:0] m_exp, m_paddr;
  bit          m_known, m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out <= 0; m_first <= 0; m_fetch <= 0; m_branch <= 0; m_stall <= 0;
      m_flags <= '0; m_exp <= '0; m_paddr <= '0; m_known <= 0; m_pend <= 0;
    end else begin : upd
      automatic logic [4:0] nw = '0;
      automatic int code = 0;
      automatic bit g = req && gnt;
      if (rvalid && !g && m_out == 0) nw[0] = 1'b1;
      if (g && !rvalid && m_out >= MAXO) nw[1] = 1'b1;
      if (m_pend && !branch && (!req || iaddr != m_paddr)) nw[2] = 1'b1;
      if (valid && m_known && addr_o != m_exp && !branch) nw[3] = 1'b1;
      if (m_out > 0 && !busy) nw[4] = 1'b1;
      for (int i = 4; i >= 0; i--) if (nw[i]) code = i + 1;
      if (g && !rvalid) m_out <= (m_out + 1 > MAXO + 1) ? MAXO + 1 : m_out + 1;
      else if (rvalid && !g && m_out > 0) m_out <= m_out - 1;
      m_pend  <= req && !gnt;
      m_paddr <= iaddr;
      if (branch) begin
        m_exp <= addr_i; m_known <= 1;
      end else if (valid && ready) begin
        m_exp <= m_exp + ((rdata[1:0] == 2'b11) ? 32'd4 : 32'd2);
      end
      if (clear) begin
        m_flags <= nw; m_first <= code;
        m_fetch <= 0; m_branch <= 0; m_stall <= 0;
      end else begin
        m_flags <= m_flags | nw;
        if (m_first == 0) m_first <= code;
        if (valid && ready && m_fetch < CNTMAX) m_fetch <= m_fetch + 1;
        if (branch && m_branch < CNTMAX) m_branch <= m_branch + 1;
        if (valid && !ready && m_stall < CNTMAX) m_stall <= m_stall + 1;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, hold the DUT against the model
  always @(negedge clk) begin
    chk("flags",  flags, m_flags);
    chk("first",  first, m_first);
    chk("outst",  outst, m_out);
    chk("fetch",  fcnt,  m_fetch);
    chk("branch", bcnt,  m_branch);
    chk("stall",  scnt,  m_stall);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    clear = 0; branch = 0; valid = 0; ready = 0; req = 0; gnt = 0; rvalid = 0; busy = 1;
  endtask

  task automatic fetch1(input logic [31:0] a, input logic [1:0] lo);
    valid = 1; ready = 1; addr_o = a; rdata = {30'h0, lo}; step();
  endtask

  task automatic reset_pulse();
    rst = 1; step(); rst = 0; step();
  endtask

  task automatic do_clear();
    idle(); clear = 1; step(); clear = 0;
  endtask

  initial begin
    idle(); rst = 1; addr_i = 0; addr_o = 0; rdata = 0; iaddr = 0;
    step(); step();
    chk("rst_flags", flags, 0); chk("rst_first", first, 0); chk("rst_out", outst, 0);
    chk("rst_fetch", fcnt, 0);  chk("rst_branch", bcnt, 0);  chk("rst_stall", scnt, 0);
    rst = 0; step();

    // Legal mixed-length sequence from a branch
    branch = 1; addr_i = 32'h100; step(); branch = 0;
    fetch1(32'h100, 2'b11); fetch1(32'h104, 2'b01); fetch1(32'h106, 2'b11);
    idle(); step();
    chk("seq_ok_flags", flags, 0); chk("seq_ok_fetch", fcnt, 3); chk("seq_ok_branch", bcnt, 1);

    // Wrong second address flags one cycle later
    do_clear();
    branch = 1; addr_i = 32'h100; step(); branch = 0;
    fetch1(32'h100, 2'b11);
    chk("seq_pre", flags[3], 0);
    fetch1(32'h108, 2'b01);
    chk("seq_err_flag", flags, 5'b01000); chk("seq_err_first", first, 4);
    fetch1(32'h106, 2'b11);
    idle(); step();
    chk("seq_err_hold", flags, 5'b01000);

    // Overflow: three grants, no responses
    do_clear();
    req = 1; gnt = 1; iaddr = 32'h0; step(); step(); step();
    idle();
    chk("ovf_out", outst, 3); chk("ovf_flags", flags, 5'b00010); chk("ovf_first", first, 2);
    rvalid = 1; step(); step(); step(); idle(); step();
    chk("ovf_drain", outst, 0);

    // Spurious response straight after reset
    reset_pulse();
    rvalid = 1; step(); idle();
    chk("spur_flags", flags, 5'b00001); chk("spur_first", first, 1); chk("spur_out", outst, 0);

    // Stalled request changes address
    reset_pulse();
    req = 1; gnt = 0; iaddr = 32'h200; step();
    gnt = 1; iaddr = 32'h204; step(); idle();
    chk("unst_flags", flags, 5'b00100); chk("unst_first", first, 3);
    rvalid = 1; step(); idle();

    // Same change but waived by a redirect
    do_clear();
    req = 1; gnt = 0; iaddr = 32'h200; step();
    branch = 1; addr_i = 32'h0; gnt = 1; iaddr = 32'h204; step(); idle();
    rvalid = 1; step(); idle(); step();
    chk("unst_waive", flags, 0);

    // Address wrap through all-ones
    do_clear();
    branch = 1; addr_i = 32'hFFFF_FFFE; step(); branch = 0;
    fetch1(32'hFFFF_FFFE, 2'b00); fetch1(32'h0000_0000, 2'b11);
    idle(); step();
    chk("wrap_flags", flags, 0); chk("wrap_fetch", fcnt, 2);

    // Outstanding response while not busy
    do_clear();
    req = 1; gnt = 1; step(); idle();
    busy = 0; step(); busy = 1;
    chk("busy_flags", flags, 5'b10000); chk("busy_first", first, 5);
    rvalid = 1; step(); idle();

    // Long stall saturates the counter
    do_clear();
    branch = 1; addr_i = 32'h40; valid = 1; ready = 0; addr_o = 32'h40; step();
    branch = 0;
    for (int i = 0; i < (1 << CW) + 4; i++) step();
    chk("stall_sat", scnt, CNTMAX); chk("stall_noerr", flags, 0);
    idle();

    // Asynchronous reset mid-burst
    req = 1; gnt = 1; step(); step();
    chk("burst_out", outst, 2);
    #2 rst = 1;
    #1;
    chk("arst_flags", flags, 0); chk("arst_first", first, 0); chk("arst_out", outst, 0);
    chk("arst_fetch", fcnt, 0);  chk("arst_branch", bcnt, 0);  chk("arst_stall", scnt, 0);
    @(negedge clk); idle(); rst = 0; step();

    // Clear racing a new spurious response: the new error survives
    req = 1; gnt = 1; step(); idle();
    busy = 0; step(); busy = 1;
    rvalid = 1; step(); idle();
    chk("pre_clr_flags", flags, 5'b10000);
    clear = 1; rvalid = 1; step(); idle(); step();
    chk("clr_spur_flags", flags, 5'b00001); chk("clr_spur_first", first, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ibex_prefetch_checker.md
Name: ibex_prefetch_checker

Overview:
Passive, parametrised protocol checker and statistics block that attaches to the ibex prefetch buffer. It snoops both the core-side (branch/valid/ready) and memory-side (req/gnt/rvalid) interfaces. It tracks outstanding bus transactions and the expected fetch-address sequence, raises sticky per-rule error flags, and keeps saturating performance counters. It drives no prefetch-buffer signals and is instantiated beside the buffer in simulation and FPGA debug builds.

Parameters:
AddrWidth, 32, width of all address ports and the expected-address register
MaxOutstanding, 2, legal maximum number of granted-but-unanswered bus requests
CntWidth, 16, width of each saturating statistics counter
CheckAddrSeq, 1'b1, enables the addr_o sequence rule; when 0, ERR_ADDR_SEQ is never set

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
clear_i  in  1  synchronous clear of error flags, first-error capture and counters
branch_i  in  1  core branch/redirect
addr_i  in  AddrWidth  branch target
valid_o  in  1  prefetch output valid (snooped)
ready_i  in  1  core ready (snooped)
addr_o  in  AddrWidth  prefetch output address (snooped)
rdata_o  in  32  prefetch output instruction (snooped)
busy_o  in  1  prefetch busy (snooped)
instr_req_o  in  1  bus request (snooped)
instr_gnt_i  in  1  bus grant
instr_addr_o  in  AddrWidth  bus address (snooped)
instr_rvalid_i  in  1  bus response valid
err_flags_o  out  5  sticky error flags, indexed by ERR_* constants
first_err_o  out  3  code of first error since reset/clear (0 = none)
outstanding_o  out  $clog2(MaxOutstanding+2)  current outstanding count
fetch_cnt_o  out  CntWidth  accepted instructions (valid_o & ready_i)
branch_cnt_o  out  CntWidth  branch_i cycles
stall_cnt_o  out  CntWidth  valid_o & !ready_i cycles

Behaviour:
- Reset (rst_i=1, asynchronous): all outputs, counters, flags and first_err_o = 0. Expected address = 0 and exp_known = 0. Reset mid-operation discards all tracked state immediately.
- clear_i: same effect as reset on the next edge, except exp_known and outstanding tracking are kept. clear_i together with a new error: the new error is still recorded (set wins over clear).
- Outstanding counter:
  - +1 on instr_req_o & instr_gnt_i; -1 on instr_rvalid_i; unchanged when both occur.
  - ERR_SPURIOUS (idx 0, code 1): rvalid with count=0 and no same-cycle grant; count stays 0.
  - ERR_OVERFLOW (idx 1, code 2): count would exceed MaxOutstanding; count saturates at MaxOutstanding+1.
  - branch_i does not alter the count; in-flight responses still arrive.
- Request stability, ERR_REQ_UNSTABLE (idx 2, code 3): a cycle with instr_req_o & !instr_gnt_i must be followed by instr_req_o=1 with an unchanged instr_addr_o. The rule is waived if branch_i is high in the following cycle.
- Address sequence, ERR_ADDR_SEQ (idx 3, code 4):
  - On branch_i: expected = addr_i, exp_known = 1. Branch has priority over a simultaneous handshake.
  - On valid_o & ready_i without branch: expected += 4 if rdata_o[1:0]==2'b11, else += 2. Arithmetic is modulo 2^AddrWidth; wrap from all-ones is legal.
  - Error if valid_o & exp_known & (addr_o != expected) & !branch_i.
- Busy, ERR_BUSY (idx 4, code 5): outstanding>0 while busy_o=0.
- Flags are sticky. first_err_o latches only when it is 0. If several rules fire in one cycle, the lowest code is latched.
- Counters increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
- All checks are evaluated combinationally each cycle and registered, so a flag is visible 1 cycle after the violating cycle.

Decomposition:
- Package ibex_prefetch_checker_pkg holds:
  - ERR_SPURIOUS..ERR_BUSY index localparams and NumErr=5
  - err_code_e enum (3 bits, ERR_NONE=0..5)
  - an inc_len(rdata) function returning 2 or 4
- One sub-module, ibex_prefetch_checker_sat_cnt (parameter Width; ports inc_i, clr_i, cnt_o), instantiated three times.

Test Plan:
- Branch to 0x100, then three accepted instructions with rdata_o[1:0] = 11,01,11 and addr_o = 0x100,0x104,0x106 -> err_flags_o=0, fetch_cnt_o=3, branch_cnt_o=1.
- Same sequence but second addr_o=0x108 -> err_flags_o[3]=1 one cycle later, first_err_o=4, later checks unaffected.
- Three grants without rvalid (MaxOutstanding=2) -> err_flags_o[1]=1, outstanding_o=3. rvalid with count 0 after reset -> err_flags_o[0]=1, first_err_o=1.
- req=1, gnt=0 at addr 0x200, next cycle addr 0x204 without branch -> err_flags_o[2]=1. Repeat with branch_i in that cycle -> no flag.
- AddrWidth=32, branch to 0xFFFF_FFFE, accept compressed instr, next addr_o=0x0000_0000 -> no error. Hold valid_o=1, ready_i=0 for 2^CntWidth+5 cycles -> stall_cnt_o=all-ones.
- Assert rst_i mid-burst with outstanding_o=2 -> all outputs 0 asynchronously. Then clear_i plus simultaneous spurious rvalid -> err_flags_o[0]=1 retained.
